// File: rtl/riscv_pkg.sv
// Shared widths and the fetch-queue entry type for the RV32I front end.
package riscv_pkg;

  localparam int XLEN     = 32;
  localparam int INSTR_W  = 32;
  localparam int OP_W     = 7;
  localparam int FUNCT3_W = 3;
  localparam int FUNCT7_W = 7;

  // One buffered instruction together with the address it was fetched from.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    pc;
  } fetch_entry_t;

  // Instructions are word aligned; the low two address bits are forced to zero.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small in-order FIFO of fetched instructions with a single-cycle flush.
// The head is read straight out of registered storage.
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  fetch_entry_t                 entry_i,
  input  logic                         pop_i,
  output fetch_entry_t                 head_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A full queue can still take a push when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Next pointers and occupancy; flush empties the queue and wins over push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only observed while the queue is non-empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= entry_i;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: issues word fetches, tracks their PCs, drops
// responses made stale by a redirect and hands {instr, pc, pc+4} to decode.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              QDEPTH   = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [XLEN-1:0]    imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               dec_valid,
  input  logic               dec_ready,
  output logic [INSTR_W-1:0] dec_instr,
  output logic [XLEN-1:0]    dec_pc,
  output logic [XLEN-1:0]    dec_pcplus4,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc
);

  localparam int CW = $clog2(QDEPTH + 1);
  localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int LW = CW + 2;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_addr_q, pend_addr_d;
  logic            pending_q, pending_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   drop_q, drop_d;

  logic [XLEN-1:0] trk_q [QDEPTH];
  logic [AW-1:0]   trk_wr_q, trk_rd_q;

  fetch_entry_t    q_head;
  fetch_entry_t    push_entry;
  logic            q_full, q_empty;
  logic [CW-1:0]   q_count;

  logic            dec_pop;
  logic            fresh_ok;
  logic            req_fire;
  logic            rsp_take;
  logic            push_valid;
  logic [LW-1:0]   live;

  // Live work = queued (minus the head leaving now) + undropped outstanding fetches.
  // Counting the departing head as free keeps one instruction per cycle flowing.
  assign dec_pop  = dec_valid && dec_ready;
  assign live     = LW'(q_count) - LW'(dec_pop) + LW'(inflight_q) + LW'(pending_q) - LW'(drop_q);
  assign fresh_ok = (live < LW'(QDEPTH)) && (inflight_q < CW'(QDEPTH));

  // A request that was raised without ready stays up with its original address.
  assign imem_req_valid = !reset && (pending_q || fresh_ok);
  assign imem_req_addr  = pending_q ? pend_addr_q : pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_take       = imem_rsp_valid && (inflight_q != '0);
  assign push_valid     = rsp_take && (drop_q == '0) && !redirect_valid;

  assign push_entry = '{instr: imem_rsp_data, pc: trk_q[trk_rd_q]};

  // PC advances when a fresh request is launched; a held request keeps its own
  // copy of the address, so a redirect can retarget pc without disturbing it.
  always_comb begin
    pc_d        = pc_q;
    pend_addr_d = pend_addr_q;
    pending_d   = 1'b0;
    inflight_d  = inflight_q;
    drop_d      = drop_q;

    if (imem_req_valid && !pending_q) pc_d = pc_q + XLEN'(4);
    if (imem_req_valid && !imem_req_ready) begin
      pending_d   = 1'b1;
      pend_addr_d = imem_req_addr;
    end

    case ({req_fire, rsp_take})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase

    if (rsp_take && (drop_q != '0)) drop_d = drop_q - CW'(1);

    // Everything already issued or still held is now stale and must be discarded.
    if (redirect_valid) begin
      pc_d   = align_pc(redirect_pc);
      drop_d = inflight_d + CW'(pending_d);
    end
  end

  // Issue and drop bookkeeping registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      pend_addr_q <= '0;
      pending_q   <= 1'b0;
      inflight_q  <= '0;
      drop_q      <= '0;
    end else begin
      pc_q        <= pc_d;
      pend_addr_q <= pend_addr_d;
      pending_q   <= pending_d;
      inflight_q  <= inflight_d;
      drop_q      <= drop_d;
    end
  end

  // PC tracker pointers: one slot per accepted request, freed by its response.
  always_ff @(posedge clk) begin
    if (reset) begin
      trk_wr_q <= '0;
      trk_rd_q <= '0;
    end else begin
      if (req_fire) trk_wr_q <= trk_wr_q + AW'(1);
      if (rsp_take) trk_rd_q <= trk_rd_q + AW'(1);
    end
  end

  // PC tracker storage, written with the address of each accepted request.
  always_ff @(posedge clk) begin
    if (req_fire) trk_q[trk_wr_q] <= imem_req_addr;
  end

  fetch_queue #(
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk     (clk),
    .reset   (reset),
    .flush_i (redirect_valid),
    .push_i  (push_valid),
    .entry_i (push_entry),
    .pop_i   (dec_ready),
    .head_o  (q_head),
    .full_o  (q_full),
    .empty_o (q_empty),
    .count_o (q_count)
  );

  assign dec_valid   = !q_empty;
  assign dec_instr   = dec_valid ? q_head.instr : '0;
  assign dec_pc      = dec_valid ? q_head.pc : '0;
  assign dec_pcplus4 = dec_valid ? (q_head.pc + XLEN'(4)) : '0;

  // The issue rule must leave room for every response that is kept.
  assert property (@(posedge clk) disable iff (reset)
                   !(push_valid && q_full && !dec_pop));

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
  import riscv_pkg::*;

  localparam int          QD  = 2;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        dec_valid, dec_ready;
  logic [31:0] dec_instr, dec_pc, dec_pcplus4;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(RPC), .QDEPTH(QD)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
    .dec_pcplus4    (dec_pcplus4),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Memory model: in-order responses, per-request latency in [lat_min, lat_max].
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;
  mreq_t       mq[$];
  int          last_due = -1;
  int          lat_min = 1;
  int          lat_max = 1;
  int          outstanding = 0;

  // Reference stream: after reset or a redirect, decode sees target, target+4, ...
  logic [31:0] exp_pc = RPC;
  int          dec_cnt = 0;
  int          acc_cnt = 0;
  logic [31:0] acc_log[$];
  logic [31:0] dec_pc_log[$];
  logic [31:0] dec_p4_log[$];
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr = '0;

  typedef struct {
    logic        rdy;
    logic        drdy;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_dv;
    logic [31:0] e_pc;
  } vec_t;
  vec_t vt[11];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // One clock: observe at negedge, update models, then drive the memory response.
  task automatic tick();
    mreq_t r;
    int    lat;
    @(negedge clk);
    if (!reset) begin
      if (prev_stall)
        chk("req_hold", {imem_req_valid, imem_req_addr}, {1'b1, prev_addr});
      if (dec_valid && dec_ready && !redirect_valid) begin
        chk("dec_stream", {dec_pc, dec_instr, dec_pcplus4},
            {exp_pc, mem_word(exp_pc), exp_pc + 32'd4});
        dec_pc_log.push_back(dec_pc);
        dec_p4_log.push_back(dec_pcplus4);
        exp_pc = exp_pc + 32'd4;
        dec_cnt++;
      end
      if (imem_req_valid && imem_req_ready) begin
        lat    = $urandom_range(lat_max, lat_min);
        r.addr = imem_req_addr;
        r.due  = cyc + lat;
        if (r.due <= last_due) r.due = last_due + 1;
        last_due = r.due;
        mq.push_back(r);
        acc_log.push_back(imem_req_addr);
        acc_cnt++;
        outstanding++;
        chk("inflight_bound", {imem_req_addr[1:0], 1'(outstanding <= QD)}, {2'b00, 1'b1});
      end
      prev_stall = imem_req_valid && !imem_req_ready;
      prev_addr  = imem_req_addr;
      if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};
    end
    @(posedge clk);
    #1;
    cyc++;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (reset) begin
      mq.delete();
      outstanding = 0;
      prev_stall  = 1'b0;
      exp_pc      = RPC;
      last_due    = -1;
    end else if (mq.size() > 0 && mq[0].due <= cyc) begin
      r = mq.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(r.addr);
      outstanding--;
    end
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    imem_req_ready = 1'b0;
    dec_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    tick();
    tick();
    chk("reset_outputs", {imem_req_valid, dec_valid, dec_instr, dec_pc, dec_pcplus4}, '0);
    reset = 1'b0;
  endtask

  task automatic wait_acc(input int n, input string name);
    int k = 0;
    while (acc_cnt < n && k < 100) begin tick(); k++; end
    if (acc_cnt < n) chk(name, acc_cnt, n);
  endtask

  task automatic wait_dec(input int n, input string name);
    int k = 0;
    while (dec_cnt < n && k < 100) begin tick(); k++; end
    if (dec_cnt < n) chk(name, dec_cnt, n);
  endtask

  task automatic redirect_to(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    int a0, d0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;

    // Test 1: table of per-cycle expectations, ready=1, 1-cycle memory.
    vt[0]  = '{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
    vt[1]  = '{1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
    vt[2]  = '{1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
    vt[3]  = '{1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
    vt[4]  = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
    vt[5]  = '{1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'h0C};
    vt[6]  = '{1'b0, 1'b1, 1'b1, 32'h18, 1'b1, 32'h10};
    vt[7]  = '{1'b0, 1'b1, 1'b1, 32'h18, 1'b1, 32'h14};
    vt[8]  = '{1'b1, 1'b1, 1'b1, 32'h18, 1'b0, 32'h00};
    vt[9]  = '{1'b1, 1'b1, 1'b1, 32'h1C, 1'b0, 32'h00};
    vt[10] = '{1'b1, 1'b1, 1'b1, 32'h20, 1'b1, 32'h18};

    do_reset();
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 11; i++) begin
      imem_req_ready = vt[i].rdy;
      dec_ready      = vt[i].drdy;
      #3;
      chk($sformatf("t1_req_c%0d", i), {imem_req_valid, imem_req_addr, dec_valid},
          {vt[i].e_rv, vt[i].e_addr, vt[i].e_dv});
      if (vt[i].e_dv)
        chk($sformatf("t1_dec_c%0d", i), {dec_pc, dec_instr}, {vt[i].e_pc, mem_word(vt[i].e_pc)});
      tick();
    end

    // Test 2: decode stalled for 10 cycles, then released.
    do_reset();
    imem_req_ready = 1'b1;
    dec_ready      = 1'b0;
    a0 = acc_cnt;
    repeat (10) tick();
    chk("t2_accepts", acc_cnt - a0, QD);
    chk("t2_head", {dec_valid, dec_pc}, {1'b1, 32'h0});
    dec_ready = 1'b1;
    d0 = dec_cnt;
    repeat (8) tick();
    chk("t2_release_count", dec_cnt - d0, 8);

    // Test 3: redirect with two requests in flight.
    do_reset();
    lat_min = 3; lat_max = 3;
    imem_req_ready = 1'b1;
    dec_ready      = 1'b1;
    tick();
    tick();
    redirect_to(32'h100);
    a0 = acc_cnt;
    d0 = dec_cnt;
    wait_acc(a0 + 1, "t3_acc_timeout");
    chk("t3_next_addr", acc_log[a0], 32'h100);
    wait_dec(d0 + 1, "t3_dec_timeout");
    chk("t3_next_dec", dec_pc_log[d0], 32'h100);

    // Test 4: request held without ready, then redirected to an unaligned target.
    do_reset();
    lat_min = 1; lat_max = 1;
    imem_req_ready = 1'b0;
    dec_ready      = 1'b1;
    repeat (3) tick();
    #3;
    chk("t4_addr_hold", {imem_req_valid, imem_req_addr}, {1'b1, 32'h0});
    redirect_to(32'h203);
    imem_req_ready = 1'b1;
    a0 = acc_cnt;
    d0 = dec_cnt;
    wait_acc(a0 + 2, "t4_acc_timeout");
    chk("t4_old_then_new", {acc_log[a0], acc_log[a0 + 1]}, {32'h0, 32'h200});
    wait_dec(d0 + 1, "t4_dec_timeout");
    chk("t4_next_dec", dec_pc_log[d0], 32'h200);

    // Test 5: PC wrap at the top of the address space.
    redirect_to(32'hFFFF_FFFC);
    a0 = acc_cnt;
    d0 = dec_cnt;
    wait_acc(a0 + 2, "t5_acc_timeout");
    chk("t5_wrap_addr", {acc_log[a0], acc_log[a0 + 1]}, {32'hFFFF_FFFC, 32'h0});
    wait_dec(d0 + 2, "t5_dec_timeout");
    chk("t5_wrap_dec", {dec_pc_log[d0], dec_p4_log[d0], dec_pc_log[d0 + 1]},
        {32'hFFFF_FFFC, 32'h0, 32'h0});

    // Test 6: random readiness, latency 1-4, random redirects and a mid-run reset.
    lat_min = 1; lat_max = 4;
    d0 = dec_cnt;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      imem_req_ready = ($urandom_range(0, 3) != 0);
      dec_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 24) == 0);
      redirect_pc    = $urandom();
      tick();
    end
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    dec_ready      = 1'b1;
    repeat (40) tick();
    chk("t6_drop_zero", dut.drop_q, 0);
    chk("t6_progress", 1'(dec_cnt - d0 > 200), 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
